// File: rtl/seq_divider_pkg.sv
// ============================================================================
//  Module  : seq_divider_pkg
//  Brief   : Shared types and constants for the sequential divider.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package seq_divider_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    localparam logic [XLEN-1:0] DIV0_QUOTIENT = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
//  Module  : div_step
//  Brief   : One restoring shift-subtract iteration on {rem, quo}.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_shift = {rem_i, quo_i[XLEN-1]};
        w_diff  = w_shift - {1'b0, dvs_i};
        // A clear borrow bit means the trial subtraction stayed non-negative.
        if (!w_diff[XLEN]) begin
            rem_o = w_diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = w_shift[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module  : seq_divider
//  Brief   : Multi-cycle restoring divider with DIV/DIVU/REM/REMU semantics.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int XLEN = seq_divider_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);

    import seq_divider_pkg::*;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [XLEN-1:0]    dvs_q, dvs_d;
    logic               signed_q, signed_d;
    logic               sgn1_q, sgn1_d;
    logic               sgn2_q, sgn2_d;
    logic [XLEN-1:0]    quotient_q, quotient_d;
    logic [XLEN-1:0]    remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic [XLEN-1:0]    w_abs1, w_abs2;
    logic [XLEN-1:0]    w_step_rem, w_step_quo;
    logic               w_overflow;
    logic               w_neg_quo, w_neg_rem;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (w_step_rem),
        .quo_o (w_step_quo)
    );

    assign w_abs1     = (is_signed && in1[XLEN-1]) ? (~in1 + XLEN'(1)) : in1;
    assign w_abs2     = (is_signed && in2[XLEN-1]) ? (~in2 + XLEN'(1)) : in2;
    assign w_overflow = is_signed && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == {XLEN{1'b1}});
    assign w_neg_quo  = signed_q && (sgn1_q ^ sgn2_q);
    assign w_neg_rem  = signed_q && sgn1_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        signed_d    = signed_q;
        sgn1_d      = sgn1_q;
        sgn2_d      = sgn2_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    signed_d = is_signed;
                    sgn1_d   = in1[XLEN-1];
                    sgn2_d   = in2[XLEN-1];
                    rem_d    = '0;
                    quo_d    = w_abs1;
                    dvs_d    = w_abs2;
                    cnt_d    = '0;
                    // Degenerate operands skip the iteration loop entirely.
                    if (in2 == '0) begin
                        quotient_d  = XLEN'(DIV0_QUOTIENT);
                        remainder_d = in1;
                        dbz_d       = 1'b1;
                        state_d     = ST_FIN;
                    end else if (w_overflow) begin
                        quotient_d  = in1;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                        state_d     = ST_FIN;
                    end else begin
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rem_d = w_step_rem;
                quo_d = w_step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    quotient_d  = w_neg_quo ? (~w_step_quo + XLEN'(1)) : w_step_quo;
                    remainder_d = w_neg_rem ? (~w_step_rem + XLEN'(1)) : w_step_rem;
                    dbz_d       = 1'b0;
                    state_d     = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            signed_q    <= 1'b0;
            sgn1_q      <= 1'b0;
            sgn2_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            signed_q    <= signed_d;
            sgn1_q      <= sgn1_d;
            sgn2_q      <= sgn2_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_FIN);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module  : tb_seq_divider
//  Brief   : Directed self-checking bench for seq_divider.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int checks;
    int failures;

    seq_divider #(.XLEN(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .in1         (in1),
        .in2         (in2),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start is driven for cycle 1; observation is on falling edges, so the
    // cycle right after the accepting edge is cycle 2. No checking in here.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input int extra_at, input logic [63:0] ea, input logic [63:0] eb,
                          output logic [63:0] q, output logic [63:0] r, output logic z,
                          output int lat, output logic busy2, output logic [63:0] midq,
                          output int npulses);
        lat = -1; npulses = 0; q = '0; r = '0; z = 1'b0; busy2 = 1'b0; midq = '0;
        @(negedge clk);
        in1 = a; in2 = b; is_signed = s; start = 1'b1;
        for (int cyc = 2; cyc <= 80; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == extra_at) begin
                in1 = ea; in2 = eb; start = 1'b1;
            end
            if (cyc == 2) busy2 = busy;
            if (cyc == 5) midq = quotient;
            if (done) begin
                npulses++;
                if (lat < 0) begin
                    lat = cyc; q = quotient; r = remainder; z = div_by_zero;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; in1 = '0; in2 = '0;
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        checks++; if (quotient !== 64'd0) begin failures++; $display("FAIL reset_quo got=%h exp=0", quotient); end
        checks++; if (remainder !== 64'd0) begin failures++; $display("FAIL reset_rem got=%h exp=0", remainder); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [63:0] q, r, mq; logic z, b2; int lat, np;
        run_op(64'd100, 64'd7, 1'b0, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (q !== 64'd14) begin failures++; $display("FAIL u100_7_quo got=%0d exp=14", q); end
        checks++; if (r !== 64'd2) begin failures++; $display("FAIL u100_7_rem got=%0d exp=2", r); end
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL u100_7_dbz got=%b exp=0", z); end
        checks++; if (lat !== 66) begin failures++; $display("FAIL u100_7_latency got=%0d exp=66", lat); end
        checks++; if (b2 !== 1'b1) begin failures++; $display("FAIL u100_7_busy got=%b exp=1", b2); end
        checks++; if (np !== 1) begin failures++; $display("FAIL u100_7_pulses got=%0d exp=1", np); end
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (q !== 64'h0FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL umax_16_quo got=%h exp=0fffffffffffffff", q); end
        checks++; if (r !== 64'd15) begin failures++; $display("FAIL umax_16_rem got=%0d exp=15", r); end
        checks++; if (mq !== 64'd14) begin failures++; $display("FAIL result_hold got=%0d exp=14", mq); end
    endtask

    task automatic test_signed();
        logic [63:0] q, r, mq; logic z, b2; int lat, np;
        run_op(-64'd100, 64'd7, 1'b1, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (q !== -64'd14) begin failures++; $display("FAIL sm100_7_quo got=%h exp=fffffffffffffff2", q); end
        checks++; if (r !== -64'd2) begin failures++; $display("FAIL sm100_7_rem got=%h exp=fffffffffffffffe", r); end
        checks++; if (lat !== 66) begin failures++; $display("FAIL sm100_7_latency got=%0d exp=66", lat); end
        run_op(64'd100, -64'd7, 1'b1, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (q !== -64'd14) begin failures++; $display("FAIL s100_m7_quo got=%h exp=fffffffffffffff2", q); end
        checks++; if (r !== 64'd2) begin failures++; $display("FAIL s100_m7_rem got=%h exp=2", r); end
        run_op(-64'd100, -64'd7, 1'b1, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (q !== 64'd14) begin failures++; $display("FAIL sm100_m7_quo got=%h exp=e", q); end
        checks++; if (r !== -64'd2) begin failures++; $display("FAIL sm100_m7_rem got=%h exp=fffffffffffffffe", r); end
    endtask

    task automatic test_div_by_zero();
        logic [63:0] q, r, mq; logic z, b2; int lat, np;
        run_op(64'h1234, 64'd0, 1'b0, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL div0_quo got=%h exp=ffffffffffffffff", q); end
        checks++; if (r !== 64'h1234) begin failures++; $display("FAIL div0_rem got=%h exp=1234", r); end
        checks++; if (z !== 1'b1) begin failures++; $display("FAIL div0_flag got=%b exp=1", z); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL div0_latency got=%0d exp=2", lat); end
        checks++; if (b2 !== 1'b0) begin failures++; $display("FAIL div0_busy got=%b exp=0", b2); end
        run_op(-64'd5, 64'd0, 1'b1, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (r !== -64'd5) begin failures++; $display("FAIL sdiv0_rem got=%h exp=fffffffffffffffb", r); end
        checks++; if (z !== 1'b1) begin failures++; $display("FAIL sdiv0_flag got=%b exp=1", z); end
    endtask

    task automatic test_overflow();
        logic [63:0] q, r, mq; logic z, b2; int lat, np;
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (q !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL ovf_quo got=%h exp=8000000000000000", q); end
        checks++; if (r !== 64'd0) begin failures++; $display("FAIL ovf_rem got=%h exp=0", r); end
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL ovf_dbz got=%b exp=0", z); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL ovf_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_busy_start();
        logic [63:0] q, r, mq; logic z, b2; int lat, np;
        run_op(64'd100, 64'd7, 1'b0, 10, 64'd50, 64'd3, q, r, z, lat, b2, mq, np);
        checks++; if (q !== 64'd14) begin failures++; $display("FAIL busy_start_quo got=%0d exp=14", q); end
        checks++; if (r !== 64'd2) begin failures++; $display("FAIL busy_start_rem got=%0d exp=2", r); end
        checks++; if (np !== 1) begin failures++; $display("FAIL busy_start_pulses got=%0d exp=1", np); end
    endtask

    task automatic test_fin_start();
        @(negedge clk);
        in1 = 64'h55; in2 = 64'd0; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL fin_done got=%b exp=1", done); end
        in1 = 64'd100; in2 = 64'd7;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fin_start_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL fin_start_done got=%b exp=0", done); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fin_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] q, r, mq; logic z, b2; int lat, np;
        int seen;
        seen = 0;
        @(negedge clk);
        in1 = 64'd1000; in2 = 64'd3; is_signed = 1'b0; start = 1'b1;
        for (int cyc = 2; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
        checks++; if (quotient !== 64'd0) begin failures++; $display("FAIL rstmid_quo got=%h exp=0", quotient); end
        checks++; if (remainder !== 64'd0) begin failures++; $display("FAIL rstmid_rem got=%h exp=0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL rstmid_dbz got=%b exp=0", div_by_zero); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_resume got=%0d exp=0", seen); end
        run_op(64'd100, 64'd7, 1'b0, 0, '0, '0, q, r, z, lat, b2, mq, np);
        checks++; if (q !== 64'd14) begin failures++; $display("FAIL post_rst_quo got=%0d exp=14", q); end
        checks++; if (r !== 64'd2) begin failures++; $display("FAIL post_rst_rem got=%0d exp=2", r); end
        checks++; if (lat !== 66) begin failures++; $display("FAIL post_rst_latency got=%0d exp=66", lat); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_busy_start();
        test_fin_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: XLEN, 64, operand/result width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a division; sampled only in IDLE.
REQ-005 Port: is_signed  input  1  1 = DIV/REM two's-complement semantics, 0 = DIVU/REMU.
REQ-006 Port: in1  input  XLEN  dividend; sampled with start.
REQ-007 Port: in2  input  XLEN  divisor; sampled with start.
REQ-008 Port: busy  output  1  high from the edge that accepts start until the edge that raises done.
REQ-009 Port: done  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 Port: quotient  output  XLEN  quotient; held until the next accepted start.
REQ-011 Port: remainder  output  XLEN  remainder; held until the next accepted start.
REQ-012 Port: div_by_zero  output  1  high with done when in2 was 0; held with the results.

Function
REQ-013 FSM states SHALL be IDLE, RUN and FIN.
- IDLE->RUN on start.
- RUN->FIN after 64 iterations.
- FIN->IDLE after one cycle, with done=1 in that cycle.
REQ-014 Operand latch: start in IDLE SHALL latch operand magnitudes (abs value if is_signed), both result signs and is_signed, and clear the iteration counter.
REQ-015 Iteration: each RUN cycle SHALL do one restoring step.
- Shift {rem, quo} left 1.
- Trial-subtract divisor from the XLEN+1-bit partial remainder.
- Keep the difference and set the quotient bit if non-negative; otherwise restore.
REQ-016 Counter: the iteration counter SHALL be 7 bits, incremented every RUN cycle; RUN exits when it reaches XLEN-1 after that step.
REQ-017 Sign fix: on entry to FIN, a signed operation SHALL negate the quotient if operand signs differ and give the remainder the dividend's sign.
REQ-018 Normal latency: done SHALL be high exactly 66 cycles after the cycle in which start was sampled.
REQ-019 Divide by zero: in2==0 SHALL bypass RUN (IDLE->FIN) and return quotient = all ones, remainder = in1, div_by_zero=1; done 2 cycles after start.
REQ-020 Signed overflow: is_signed with in1 = most-negative and in2 = -1 SHALL bypass RUN and return quotient = in1, remainder = 0; done 2 cycles after start.
REQ-021 start while busy SHALL be ignored, with no effect on the in-flight operation.
REQ-022 start in the done cycle (FIN) SHALL be ignored; a new start is accepted from IDLE only.
REQ-023 quotient, remainder and div_by_zero SHALL change only on the edge entering the done cycle.
REQ-024 busy and done SHALL never be high in the same cycle.

Reset
REQ-025 Asserting rst_n low SHALL asynchronously force:
- state IDLE
- busy=0, done=0, div_by_zero=0
- quotient=0, remainder=0
- counter=0
REQ-026 Reset mid-operation SHALL abort the division with no done pulse; operation resumes only on a fresh start after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2-bit), XLEN, the counter width, and the DIV0_QUOTIENT all-ones constant.
REQ-028 One combinational sub-module, div_step, SHALL implement a single shift-subtract-restore iteration and be instantiated once.

Verification
REQ-029 Unsigned: in1=100, in2=7, is_signed=0 -> quotient=14, remainder=2, done at cycle 66.
REQ-030 Signed: in1=-100, in2=7 -> quotient=-14, remainder=-2; in1=100, in2=-7 -> quotient=-14, remainder=2.
REQ-031 Divide by zero: in1=0x1234, in2=0 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1, done at cycle 2.
REQ-032 Overflow: in1=0x8000_0000_0000_0000, in2=-1, signed -> quotient=0x8000_0000_0000_0000, remainder=0, done at cycle 2.
REQ-033 Busy-start: pulse start with new operands at cycle 10 of a running divide -> first result unchanged and only one done pulse.
REQ-034 Reset mid-op: drop rst_n at cycle 30 -> all outputs 0 immediately and no done; a following 100/7 division is correct.
